// File: rtl/param_stream_demux_pkg.sv
// Shared constants and helpers for the parametrised stream demux.
// Optional stats build: define PARAM_STREAM_DEMUX_STATS_EN.
package param_stream_demux_pkg;

  localparam int STATS_CNT_W = 16;

  // Low bit of channel k inside a packed per-channel bus.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/demux_channel_slot.sv
// Single-entry holding register for one demux output channel.
// Drain counter added when PARAM_STREAM_DEMUX_STATS_EN is defined.
import param_stream_demux_pkg::*;

module demux_channel_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
`ifdef PARAM_STREAM_DEMUX_STATS_EN
  output logic [STATS_CNT_W-1:0] out_count,
`endif
  output logic             slot_ready
);

  logic drain;

  assign drain      = out_valid & out_ready;
  assign slot_ready = !out_valid | out_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fill) begin
      out_valid <= 1'b1;
      out_data  <= fill_data;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

`ifdef PARAM_STREAM_DEMUX_STATS_EN
  // Wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_count <= '0;
    end else if (drain) begin
      out_count <= out_count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/param_stream_demux.sv
// Registered 1-to-N valid/ready demux with per-channel holding slots.
// Optional stats ports: define PARAM_STREAM_DEMUX_STATS_EN.
import param_stream_demux_pkg::*;

module param_stream_demux #(
  parameter int WIDTH   = 8,
  parameter int NUM_OUT = 4,
  parameter int SEL_W   = $clog2(NUM_OUT)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data,
`ifdef PARAM_STREAM_DEMUX_STATS_EN
  output logic [NUM_OUT*STATS_CNT_W-1:0] out_count,
  output logic [STATS_CNT_W-1:0]   drop_count,
`endif
  output logic                     sel_err,
  output logic                     busy
);

  localparam logic [SEL_W:0] NOUT = (SEL_W+1)'(NUM_OUT);

  logic [NUM_OUT-1:0] hit;
  logic [NUM_OUT-1:0] fill;
  logic [NUM_OUT-1:0] slot_ready;
  logic               in_range;
  logic               sel_rdy;
  logic               accept;
  logic               drop;

  always_comb begin
    hit = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      hit[k] = (in_sel == SEL_W'(k));
    end
  end

  // Widened compare stays meaningful when NUM_OUT is a power of two.
  assign in_range = {1'b0, in_sel} < NOUT;
  assign sel_rdy  = |(hit & slot_ready);
  assign in_ready = reset_n & (in_range ? sel_rdy : 1'b1);
  assign accept   = in_valid & in_ready;
  assign drop     = accept & !in_range;
  assign fill     = accept ? hit : '0;
  assign busy     = |out_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= drop;
    end
  end

`ifdef PARAM_STREAM_DEMUX_STATS_EN
  // Saturating, updated alongside the sel_err pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (drop && drop_count != '1) begin
      drop_count <= drop_count + 1'b1;
    end
  end
`endif

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    demux_channel_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .fill      (fill[k]),
      .fill_data (in_data),
      .out_ready (out_ready[k]),
      .out_valid (out_valid[k]),
      .out_data  (out_data[slice_lo(k, WIDTH) +: WIDTH]),
`ifdef PARAM_STREAM_DEMUX_STATS_EN
      .out_count (out_count[slice_lo(k, STATS_CNT_W) +: STATS_CNT_W]),
`endif
      .slot_ready(slot_ready[k])
    );
  end

endmodule

// File: doc/param_stream_demux.md
Name: param_stream_demux

Overview:
- Parametrised, registered 1-to-N demultiplexer. Successor to the 4-bit 1-to-2 gate-level demux.
- Routes one input word per cycle to one of NUM_OUT output channels using valid/ready handshakes.
- Each output has a single-entry holding register, so a stalled channel does not block traffic to other channels.
- Sits between a producer stage and N independent consumers in the datapath.

Parameters:
- WIDTH, 8, data width in bits per word (>=1)
- NUM_OUT, 4, number of output channels (2..16)
- SEL_W, $clog2(NUM_OUT), select width (derived; do not override)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  input word present
- in_ready  out  1  input word accepted this cycle when in_valid&in_ready
- in_data  in  WIDTH  input word
- in_sel  in  SEL_W  destination channel
- out_valid  out  NUM_OUT  per-channel holding register full
- out_ready  in  NUM_OUT  per-channel consumer accepts
- out_data  out  NUM_OUT*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel_err  out  1  one-cycle pulse: out-of-range select dropped
- busy  out  1  OR of out_valid

Behaviour:
- Reset: synchronous, active-low; clk and reset_n are the only clock and reset. When reset_n=0 at a rising edge, out_valid=0, out_data=0, sel_err=0, and busy=0 from the next cycle. Reset mid-transfer discards all held words and no handshake completes in that cycle. in_ready=0 while reset_n=0.
- Accept: accept = in_valid & in_ready. The transfer completes in the cycle where accept=1.
- in_ready (combinational):
  - in-range sel: in_ready = !out_valid[in_sel] | out_ready[in_sel].
  - out-of-range sel (in_sel >= NUM_OUT): in_ready = 1.
  - Combinational path out_ready -> in_ready is intentional and documented.
- Channel k register update per cycle:
  - fill = accept & (in_sel==k); drain = out_valid[k] & out_ready[k].
  - fill: out_data[k] <= in_data, out_valid[k] <= 1. A simultaneous drain+fill gives full throughput of 1 word/cycle per channel.
  - drain without fill: out_valid[k] <= 0; out_data[k] holds its last value.
  - neither: hold.
- Latency: exactly 1 cycle from accept to out_valid[k]=1 with the word.
- Other channels are unaffected by a fill on channel k. At most one channel fills per cycle.
- Out-of-range sel: the word is accepted and discarded, no out_valid changes, and sel_err=1 in the following cycle only. sel_err is registered.
- in_data and in_sel must be stable while in_valid=1 and in_ready=0. out_data[k] is stable while out_valid[k]=1 and out_ready[k]=0.
- No internal FSM beyond the per-channel full/empty bit.

Optional Feature:
- Macro: PARAM_STREAM_DEMUX_STATS_EN.
- When defined, the block adds a port:
  - out_count  out  NUM_OUT*16  per-channel 16-bit count of drains; increments when out_valid[k]&out_ready[k]; wraps 0xFFFF->0x0000; reset to 0.
- It also adds a 16-bit drop counter, exported on port drop_count (out, 16), which increments with each sel_err pulse and saturates at 0xFFFF.
- When undefined, these ports and registers do not exist and all other behaviour is identical.

Decomposition:
- Shared package param_stream_demux_pkg: STATS_CNT_W=16 and a function for the per-channel data slice index.
- One natural sub-module, demux_channel_slot, instantiated NUM_OUT times via generate:
  - inputs: clk, reset_n, fill, fill_data, out_ready
  - outputs: out_valid, out_data, slot_ready
  - contains the optional counter under the macro.
- The top module holds select decode, in_ready mux, and sel_err.

Test Plan:
- Reset: drive reset_n=0 for 2 cycles mid-stream with channels 1 and 3 full -> out_valid=4'b0000, out_data=0, sel_err=0, in_ready=0 during reset.
- Routing: in_sel=2, in_data=8'hA5, all out_ready=0 -> next cycle out_valid=4'b0100, channel 2 data=8'hA5; same-channel second word stalls (in_ready=0) until out_ready[2]=1.
- Streaming: continuous words 0x01..0x10 to sel=1 with out_ready[1]=1 -> one word/cycle, in_ready never drops, outputs in order with 1-cycle latency.
- Isolation: channel 0 full and stalled; send 0x33 to sel=3 -> accepted immediately, out_valid=4'b1001, channel 0 still 0x.. unchanged.
- Out-of-range: NUM_OUT=3, in_sel=3, in_data=0x7E -> in_ready=1, no out_valid change, sel_err=1 for exactly one cycle; with PARAM_STREAM_DEMUX_STATS_EN, drop_count=1.
- Stats wrap: with PARAM_STREAM_DEMUX_STATS_EN, 65537 drains on channel 0 -> out_count[0]=1; channel counts for other channels remain 0.
